// File: rtl/flow_zigzag_if.sv
// Coefficient stream bundle for flow_zigzag: raster-order input side, zigzag-order output side.
interface flow_zigzag_if #(
  parameter int N = 2
);
  typedef logic signed [15:0] coef_t;

  logic            in_valid;
  coef_t [N-1:0]   in_data;
  logic            in_sob;
  logic            in_eob;
  logic            in_sof;

  logic            out_valid;
  coef_t [N-1:0]   out_data;
  logic            out_sob;
  logic            out_eob;
  logic            out_sof;

  modport master (
    output in_valid, in_data, in_sob, in_eob, in_sof,
    input  out_valid, out_data, out_sob, out_eob, out_sof
  );

  modport slave (
    input  in_valid, in_data, in_sob, in_eob, in_sof,
    output out_valid, out_data, out_sob, out_eob, out_sof
  );
endinterface

// File: rtl/flow_zigzag.sv
// Ping-pong 8x8 raster-to-zigzag reorder buffer, N coefficients per beat.
// Define FLOW_ZIGZAG_CHECK_EN to enable the sticky block-length/overflow err flag.
module flow_zigzag #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  flow_zigzag_if.slave bus,
  output logic         err
);
  localparam int         BEATS = 64 / N;
  localparam logic [5:0] LAST  = 6'(BEATS - 1);

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {RD_IDLE, RD_BUSY} rd_state_e;

  rd_state_e          state_q, state_d;
  logic [5:0]         wcnt_q, wcnt_d;
  logic [5:0]         rcnt_q, rcnt_d;
  logic               bank_sel_q, bank_sel_d;
  logic               sof_wr_q, sof_wr_d;
  logic               sof_rd_q, sof_rd_d;
  logic               acc, rd_last, rd_free;
  logic [5:0]         wpos;
  logic signed [15:0] bank_q [2][64];

  assign acc     = en & bus.in_valid;
  assign rd_last = (state_q == RD_BUSY) && (rcnt_q == LAST);
  // Reader finishing its last beat this cycle counts as free so blocks chain with no bubble.
  assign rd_free = (state_q == RD_IDLE) || rd_last;
  assign wpos    = bus.in_sob ? '0 : wcnt_q;

  always_comb begin
    state_d    = state_q;
    rcnt_d     = rcnt_q;
    wcnt_d     = wcnt_q;
    bank_sel_d = bank_sel_q;
    sof_wr_d   = sof_wr_q;
    sof_rd_d   = sof_rd_q;

    if (en && state_q == RD_BUSY) begin
      if (rd_last) state_d = RD_IDLE;
      else         rcnt_d  = rcnt_q + 6'd1;
    end

    if (acc) begin
      if (bus.in_sob) sof_wr_d = bus.in_sof;
      if (bus.in_eob) begin
        wcnt_d = '0;
        if (rd_free) begin
          bank_sel_d = ~bank_sel_q;
          state_d    = RD_BUSY;
          rcnt_d     = '0;
          sof_rd_d   = bus.in_sob ? bus.in_sof : sof_wr_q;
        end
      end else if (wpos == LAST) begin
        wcnt_d = '0;
      end else begin
        wcnt_d = wpos + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RD_IDLE;
      rcnt_q     <= '0;
      wcnt_q     <= '0;
      bank_sel_q <= 1'b0;
      sof_wr_q   <= 1'b0;
      sof_rd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      wcnt_q     <= wcnt_d;
      bank_sel_q <= bank_sel_d;
      sof_wr_q   <= sof_wr_d;
      sof_rd_q   <= sof_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      for (int unsigned i = 0; i < N; i++) begin
        bank_q[bank_sel_q][6'(int'(wpos) * N + int'(i))] <= bus.in_data[i];
      end
    end
  end

  // The bank not selected for writing is always the one being read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_sob   <= 1'b0;
      bus.out_eob   <= 1'b0;
      bus.out_sof   <= 1'b0;
      bus.out_data  <= '0;
    end else if (en) begin
      bus.out_valid <= (state_q == RD_BUSY);
      bus.out_sob   <= (state_q == RD_BUSY) && (rcnt_q == '0);
      bus.out_eob   <= rd_last;
      bus.out_sof   <= (state_q == RD_BUSY) && (rcnt_q == '0) && sof_rd_q;
      if (state_q == RD_BUSY) begin
        for (int unsigned i = 0; i < N; i++) begin
          bus.out_data[i] <= bank_q[~bank_sel_q][ZZ[6'(int'(rcnt_q) * N + int'(i))]];
        end
      end
    end
  end

`ifdef FLOW_ZIGZAG_CHECK_EN
  logic err_q;
  logic chk_hit;

  always_comb begin
    chk_hit = 1'b0;
    if (acc) begin
      if (bus.in_eob) chk_hit = (wpos != LAST) || !rd_free;
      else            chk_hit = (wpos == LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (chk_hit) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_flow_zigzag.sv
// Directed bench for flow_zigzag: block-level scoreboard model plus literal spot checks.
module tb_flow_zigzag;
  localparam int N     = 2;
  localparam int BEATS = 64 / N;
`ifdef FLOW_ZIGZAG_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic en    = 1'b0;
  logic err;

  flow_zigzag_if #(.N(N)) bus();

  flow_zigzag #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus),
    .err   (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Zigzag order derived by walking anti-diagonals of the 8x8 block.
  int zz [64];
  function automatic void build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 1) for (int r = lo; r <= hi; r++) begin zz[k] = r * 8 + (s - r); k++; end
      else            for (int r = hi; r >= lo; r--) begin zz[k] = r * 8 + (s - r); k++; end
    end
  endfunction

  typedef struct packed {
    logic [N-1:0][15:0] d;
    logic [N-1:0]       k;
    logic               sob;
    logic               eob;
    logic               sof;
    int                 slot;
  } beat_t;

  beat_t       sched [$];
  logic [15:0] mem [2][64];
  bit          mk  [2][64];
  int          m_wcnt = 0, m_e = 0, m_last = 0;
  bit          m_wsel = 0, m_lat = 0, m_err = 0;
  logic               e_valid = 0, e_sob = 0, e_eob = 0, e_sof = 0;
  logic [N-1:0][15:0] e_d = '0;
  logic [N-1:0]       e_k = '0;

  always @(posedge clk or negedge rst_n) begin
    beat_t b;
    int    wpos;
    if (!rst_n) begin
      sched.delete();
      m_wcnt = 0; m_e = 0; m_last = 0; m_wsel = 0; m_lat = 0; m_err = 0;
      e_valid = 0; e_sob = 0; e_eob = 0; e_sof = 0; e_d = '0; e_k = '0;
    end else if (en) begin
      m_e++;
      if (sched.size() > 0 && sched[0].slot == m_e) begin
        b = sched.pop_front();
        e_valid = 1; e_sob = b.sob; e_eob = b.eob; e_sof = b.sof; e_d = b.d; e_k = b.k;
      end else begin
        e_valid = 0; e_sob = 0; e_eob = 0; e_sof = 0;
      end
      if (bus.in_valid) begin
        wpos = bus.in_sob ? 0 : m_wcnt;
        if (bus.in_sob) m_lat = bus.in_sof;
        for (int i = 0; i < N; i++) begin
          mem[m_wsel][wpos * N + i] = bus.in_data[i];
          mk[m_wsel][wpos * N + i]  = 1;
        end
        if (bus.in_eob) begin
          m_wcnt = 0;
          if (wpos != BEATS - 1) m_err = 1;
          if (m_last <= m_e) begin
            for (int k = 0; k < BEATS; k++) begin
              b.slot = m_e + 1 + k;
              for (int i = 0; i < N; i++) begin
                b.d[i] = mem[m_wsel][zz[k * N + i]];
                b.k[i] = mk[m_wsel][zz[k * N + i]];
              end
              b.sob = (k == 0);
              b.eob = (k == BEATS - 1);
              b.sof = (k == 0) && m_lat;
              sched.push_back(b);
            end
            m_last = m_e + BEATS;
            m_wsel = !m_wsel;
          end else begin
            m_err = 1;
          end
        end else if (wpos == BEATS - 1) begin
          m_wcnt = 0;
          m_err  = 1;
        end else begin
          m_wcnt = wpos + 1;
        end
      end
    end
  end

  int cyc = 0;
  bit w_on = 0;
  int w_valid, w_ven, w_sof, w_first, w_last;

  always @(negedge clk) begin
    cyc++;
    chk("out_valid", bus.out_valid, e_valid);
    chk("out_sob", bus.out_sob, e_sob);
    chk("out_eob", bus.out_eob, e_eob);
    chk("out_sof", bus.out_sof, e_sof);
    chk("err", err, CHK ? m_err : 1'b0);
    if (e_valid)
      for (int i = 0; i < N; i++)
        if (e_k[i]) chk($sformatf("out_data_l%0d", i), $unsigned(bus.out_data[i]), e_d[i]);
    if (w_on) begin
      if (bus.out_valid) begin
        if (w_valid == 0) w_first = cyc;
        w_last = cyc;
        w_valid++;
        if (en) w_ven++;
      end
      if (bus.out_sof) w_sof++;
    end
  end

  task automatic win_start();
    w_valid = 0; w_ven = 0; w_sof = 0; w_first = 0; w_last = -1; w_on = 1;
  endtask

  task automatic drive(input bit s, input bit e, input bit f, input int base, input int j);
    @(posedge clk); #1;
    bus.in_valid = 1; bus.in_sob = s; bus.in_eob = e; bus.in_sof = f;
    for (int i = 0; i < N; i++) bus.in_data[i] = 16'(base + j * N + i);
  endtask

  task automatic send_block(input int base, input int nbeats, input bit sof);
    for (int j = 0; j < nbeats; j++) drive(j == 0, j == nbeats - 1, sof && j == 0, base, j);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.in_valid = 0; bus.in_sob = 0; bus.in_eob = 0; bus.in_sof = 0;
    end
  endtask

  initial begin
    build_zz();
    bus.in_valid = 0; bus.in_sob = 0; bus.in_eob = 0; bus.in_sof = 0; bus.in_data = '0;
    #1 rst_n = 0;
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_eob", bus.out_eob, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1; en = 1;

    // One block, data = raster index; latency and first beats pinned by hand.
    send_block(0, BEATS, 0);
    idle(1);
    chk("t1_lat_valid0", bus.out_valid, 0);
    idle(1);
    chk("t1_b0_valid", bus.out_valid, 1);
    chk("t1_b0_sob", bus.out_sob, 1);
    chk("t1_b0_l0", bus.out_data[0], 0);
    chk("t1_b0_l1", bus.out_data[1], 1);
    idle(1);
    chk("t1_b1_l0", bus.out_data[0], 8);
    chk("t1_b1_l1", bus.out_data[1], 16);
    idle(1);
    chk("t1_b2_l0", bus.out_data[0], 9);
    chk("t1_b2_l1", bus.out_data[1], 2);
    idle(40);

    // Back-to-back blocks, second carries sof.
    win_start();
    send_block(1000, BEATS, 0);
    send_block(2000, BEATS, 1);
    idle(40);
    w_on = 0;
    chk("t2_beats", w_valid, 64);
    chk("t2_contig", w_last - w_first + 1, 64);
    chk("t2_sof", w_sof, 1);

    // Five-cycle stall in mid-read.
    win_start();
    send_block(3000, BEATS, 0);
    idle(8);
    en = 0;
    repeat (5) @(posedge clk);
    #1 en = 1;
    idle(40);
    w_on = 0;
    chk("t3_beats_en", w_ven, 32);
    chk("t3_samples", w_valid, 37);
    chk("t3_contig", w_last - w_first + 1, 37);

    // Short block: eob on beat 20.
    win_start();
    send_block(4000, 21, 0);
    idle(45);
    w_on = 0;
    chk("t4_beats", w_valid, 32);
    chk("t4_err", err, CHK);

    // Reset pulse in mid-read, then a fresh block.
    send_block(5000, BEATS, 0);
    idle(10);
    rst_n = 0;
    #1;
    chk("t5_valid", bus.out_valid, 0);
    chk("t5_sob", bus.out_sob, 0);
    chk("t5_sof", bus.out_sof, 0);
    chk("t5_data", bus.out_data, 0);
    chk("t5_err", err, 0);
    idle(2);
    rst_n = 1;
    send_block(5100, BEATS, 0);
    idle(2);
    chk("t5_fresh_l0", bus.out_data[0], 5100);
    chk("t5_fresh_l1", bus.out_data[1], 5101);
    idle(40);
    chk("t5_err_clean", err, 0);

    // Overflow: second eob 10 beats after the first is dropped.
    win_start();
    send_block(6000, BEATS, 0);
    send_block(6100, 10, 0);
    idle(45);
    w_on = 0;
    chk("t6_beats", w_valid, 32);
    chk("t6_err", err, CHK);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/flow_zigzag.md
FLOW_ZIGZAG -- requirements
Module: flow_zigzag

Interface
REQ-001 SHALL have parameter N, default 2, coefficients per beat; legal values 1, 2, 4, 8.
REQ-002 SHALL have input clk, 1 bit, clock; all state is updated on its rising edge.
REQ-003 SHALL have input rst_n, 1 bit, reset: asynchronous, active-low.
REQ-004 SHALL have input en, 1 bit, global stall; when low, all state, counters and outputs hold.
REQ-005 SHALL have input in_valid, 1 bit, beat qualifier; a beat is accepted only when in_valid & en.
REQ-006 SHALL have input in_data, N x 16 signed, raster-order coefficients; lane i of block beat j is raster index j*N+i.
REQ-007 SHALL have inputs in_sob, in_eob and in_sof, 1 bit each: first beat of block, last beat of block, and first block of frame (qualified by in_sob).
REQ-008 SHALL have output out_valid, 1 bit, output beat qualifier.
REQ-009 SHALL have output out_data, N x 16 signed; lane i of output beat k carries zigzag index k*N+i.
REQ-010 SHALL have outputs out_sob, out_eob and out_sof, 1 bit each, block and frame markers aligned to out_data.
REQ-011 SHALL have output err, 1 bit, sticky block-length/overflow flag (see Configuration).

Function
REQ-012 SHALL hold two 64x16 register banks (ping-pong); one bank is written while the other is read.
REQ-013 SHALL write each accepted beat into the write bank at raster positions wcnt*N+i, with wcnt counting 0..64/N-1.
REQ-014 SHALL force wcnt to 0 on an accepted in_sob beat before writing (resync), and latch in_sof for that block.
REQ-015 SHALL, on an accepted in_eob beat, swap banks and start reading the filled bank in the next enabled cycle, provided the reader is idle.
REQ-016 SHALL read 64/N consecutive enabled cycles with no gaps; beat k lane i = bank[ZZ[k*N+i]], using the standard JPEG zigzag table (ZZ = 0,1,8,16,9,2,3,10,17,24,...,63).
REQ-017 SHALL register out_data; first out_valid occurs 2 enabled cycles after the accepted eob beat.
REQ-018 SHALL assert out_sob on output beat 0 and out_eob on beat 64/N-1; out_sof equals the latched sof on beat 0 only; all markers are 0 when out_valid=0.
REQ-019 SHALL allow the write of block B+1 to proceed during the read of block B; back-to-back blocks SHALL produce back-to-back output with no bubble.
REQ-020 SHALL, when eob arrives while the reader is still busy (overflow), drop the new block without swapping and leave the read unaffected.
REQ-021 SHALL, when wcnt wraps past 64/N-1 without an eob, wrap to 0 and continue writing.

Reset
REQ-022 SHALL, on rst_n low, clear out_valid, out_sob, out_eob, out_sof, out_data, err, wcnt, the read counter, the bank select and the reader-busy state immediately (asynchronously).
REQ-023 SHALL abort any in-progress write or read on reset; bank contents need not be cleared.

Configuration
REQ-024 SHALL, with FLOW_ZIGZAG_CHECK_EN defined, set err and hold it until reset on any of the following: an eob with wcnt != 64/N-1, an overflow drop, or a wcnt wrap; a short block SHALL still be swapped and emitted, with unwritten positions holding stale data.
REQ-025 SHALL, without FLOW_ZIGZAG_CHECK_EN, tie err to 0 and omit the checking logic; swap and drop behaviour is otherwise unchanged.

Verification
REQ-026 SHALL cover: N=2, one block with data = raster index, sob at beat 0, eob at beat 31 -> out beats {lane0,lane1} = {0,1}, {8,16}, {9,2}, ..., {62,63}; out_sob on the first beat, out_eob on the 32nd; first out_valid 2 cycles after eob.
REQ-027 SHALL cover: two back-to-back blocks, the second with sof=1 -> 64 contiguous out_valid cycles; out_sof=1 only on beat 0 of the second block.
REQ-028 SHALL cover: en held low for 5 cycles in mid-read -> outputs frozen for those cycles; the sequence then resumes with no lost or duplicated beat.
REQ-029 SHALL cover: a block with eob at beat 20 (CHECK_EN defined) -> err=1 and 32 beats still emitted; without the macro -> err=0.
REQ-030 SHALL cover: rst_n pulsed low in mid-read -> all outputs 0 in the same cycle; after release, a fresh block is output correctly.
REQ-031 SHALL cover: a second eob arriving 10 beats after the first -> second block dropped, first block output intact, err=1 (CHECK_EN defined).
